// File: rtl/imem_fetch.sv
// Instruction memory plus fetch sequencer: stores words from the programming
// stage and replays them from address 0 as a valid/ready stream while run is high.
module imem_fetch #(
  parameter int         ADDR_W  = 8,
  parameter int         DATA_W  = 16,
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addrWr,
  input  logic [DATA_W-1:0] dataWr,
  input  logic              wrEn,
  input  logic              run,
  input  logic              instrReady,
  output logic [DATA_W-1:0] instr,
  output logic              instrValid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W:0]   progLen,
  output logic              halted
);

  // state | meaning
  // IDLE  | armed, waiting for run; pc=0, outputs low
  // FETCH | read issued at pc
  // LOAD  | RAM data valid; decode halt or present word
  // VALID | word presented, waiting for instrReady
  // DONE  | run finished, halted=1 until run drops
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_VALID, S_DONE} state_t;

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0]   rd_data;
  logic [DATA_W-1:0]   instr_nxt;
  logic                valid_nxt;
  logic                halted_nxt;
  logic [ADDR_W-1:0]   pc_nxt;
  logic [ADDR_W:0]     wr_len;
  logic [ADDR_W:0]     pc_inc;
  logic [3:0]          opcode;

  assign wr_len = {1'b0, addrWr} + ONE;
  assign pc_inc = {1'b0, pc} + ONE;
  assign opcode = rd_data[DATA_W-1 -: 4];

  // Plain RAM, no reset; read-before-write gives old data on a same-address collision.
  always_ff @(posedge clk) begin
    if (wrEn) mem[addrWr] <= dataWr;
    rd_data <= mem[pc];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      progLen <= '0;
    end else if (wrEn && (wr_len > progLen)) begin
      progLen <= wr_len;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      instr      <= '0;
      instrValid <= 1'b0;
      pc         <= '0;
      halted     <= 1'b0;
    end else begin
      state      <= state_nxt;
      instr      <= instr_nxt;
      instrValid <= valid_nxt;
      pc         <= pc_nxt;
      halted     <= halted_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    instr_nxt  = instr;
    valid_nxt  = instrValid;
    pc_nxt     = pc;
    halted_nxt = halted;
    case (state)
      S_IDLE: begin
        instr_nxt  = '0;
        valid_nxt  = 1'b0;
        pc_nxt     = '0;
        halted_nxt = 1'b0;
        if (run) begin
          if (progLen != '0) begin
            state_nxt = S_FETCH;
          end else begin
            state_nxt  = S_DONE;
            halted_nxt = 1'b1;
          end
        end
      end
      S_FETCH: begin
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (opcode == HALT_OP) begin
          state_nxt  = S_DONE;
          halted_nxt = 1'b1;
        end else begin
          state_nxt = S_VALID;
          instr_nxt = rd_data;
          valid_nxt = 1'b1;
        end
      end
      S_VALID: begin
        if (instrReady) begin
          valid_nxt = 1'b0;
          // progLen only grows, so >= is the same as reaching the last word
          if (pc_inc >= progLen) begin
            state_nxt  = S_DONE;
            halted_nxt = 1'b1;
          end else begin
            state_nxt = S_FETCH;
            pc_nxt    = pc_inc[ADDR_W-1:0];
          end
        end
      end
      S_DONE: begin
        valid_nxt = 1'b0;
        if (!run) begin
          state_nxt  = S_IDLE;
          halted_nxt = 1'b0;
          pc_nxt     = '0;
          instr_nxt  = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    // Dropping run aborts an in-flight fetch without flagging halted.
    if (!run && (state == S_FETCH || state == S_LOAD || state == S_VALID)) begin
      state_nxt  = S_IDLE;
      instr_nxt  = '0;
      valid_nxt  = 1'b0;
      pc_nxt     = '0;
      halted_nxt = 1'b0;
    end
  end

endmodule
